// File: rtl/anticipator_table_if.sv
`default_nettype none
// ============================================================================
// Module : anticipator_table_if
// Lookup, training and control bundle for anticipator_table.
// Rev    : 1.0
// ============================================================================
interface anticipator_table_if #(
  parameter int ADDR_W = 12,
  parameter int NPORTS = 4,
  parameter int CNT_W  = 2
);
  logic                     flush;
  logic [NPORTS*ADDR_W-1:0] read_addr;
  logic [NPORTS-1:0]        read_en;
  logic [NPORTS*CNT_W-1:0]  read_data;
  logic [NPORTS-1:0]        read_valid;
  logic                     upd_en;
  logic [ADDR_W-1:0]        upd_addr;
  logic                     upd_taken;
  logic                     init_busy;

  modport master (
    output flush, read_addr, read_en, upd_en, upd_addr, upd_taken,
    input  read_data, read_valid, init_busy
  );

  modport slave (
    input  flush, read_addr, read_en, upd_en, upd_addr, upd_taken,
    output read_data, read_valid, init_busy
  );
endinterface
`default_nettype wire

// File: rtl/anticipator_table.sv
`default_nettype none
// ============================================================================
// Module : anticipator_table
// Saturating-counter table: NPORTS registered lookups, one training port and
// a one-entry-per-cycle init sweep after reset or flush.
// Rev    : 1.0
// ============================================================================
module anticipator_table #(
  parameter int ADDR_W   = 12,
  parameter int NPORTS   = 4,
  parameter int CNT_W    = 2,
  parameter int INIT_VAL = 0
) (
  input  logic               clk,
  input  logic               rst,
  anticipator_table_if.slave bus
);

  localparam int                c_depth   = 2**ADDR_W;
  localparam logic [CNT_W-1:0]  c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  c_init    = CNT_W'(INIT_VAL);
  localparam logic [ADDR_W-1:0] c_last    = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        sweep_q, sweep_d;
  logic [NPORTS*CNT_W-1:0]  read_data_q, read_data_d;
  logic [NPORTS-1:0]        read_valid_q, read_valid_d;

  logic [CNT_W-1:0]         mem_q [c_depth];
  logic                     mem_wr_en;
  logic [ADDR_W-1:0]        mem_wr_addr;
  logic [CNT_W-1:0]         mem_wr_data;

  logic [CNT_W-1:0]         upd_old;
  logic [CNT_W-1:0]         upd_new;

  // Saturating step of the entry being trained; never wraps at either bound.
  always_comb begin
    upd_old = mem_q[bus.upd_addr];
    upd_new = upd_old;
    if (bus.upd_taken) begin
      if (upd_old != c_cnt_max) begin
        upd_new = upd_old + CNT_W'(1);
      end
    end else begin
      if (upd_old != '0) begin
        upd_new = upd_old - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    mem_wr_en   = 1'b0;
    mem_wr_addr = bus.upd_addr;
    mem_wr_data = upd_new;
    case (state_q)
      S_INIT: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = sweep_q;
        mem_wr_data = c_init;
        if (bus.flush) begin
          sweep_d = '0;
        end else if (sweep_q == c_last) begin
          sweep_d = '0;
          state_d = S_RUN;
        end else begin
          sweep_d = sweep_q + ADDR_W'(1);
        end
      end
      S_RUN: begin
        // A flush wins over a coincident training update.
        if (bus.flush) begin
          state_d = S_INIT;
          sweep_d = '0;
        end else if (bus.upd_en) begin
          mem_wr_en = 1'b1;
        end
      end
      default: begin
        state_d = S_INIT;
        sweep_d = '0;
      end
    endcase
  end

  // Lookups sample the table before this cycle's write, so a same-index
  // read/update returns the pre-update value.
  always_comb begin
    read_data_d  = read_data_q;
    read_valid_d = '0;
    if (state_q == S_INIT) begin
      read_data_d = '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (bus.read_en[p]) begin
          read_data_d[p*CNT_W +: CNT_W] = mem_q[bus.read_addr[p*ADDR_W +: ADDR_W]];
          read_valid_d[p]               = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_INIT;
      sweep_q      <= '0;
      read_data_q  <= '0;
      read_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      mem_q[mem_wr_addr] <= mem_wr_data;
    end
  end

  assign bus.read_data  = read_data_q;
  assign bus.read_valid = read_valid_q;
  assign bus.init_busy  = (state_q == S_INIT);

endmodule
`default_nettype wire

// File: tb/tb_anticipator_table.sv
`default_nettype none
// ============================================================================
// Module : tb_anticipator_table
// Directed and randomized checks of anticipator_table against a table model.
// Rev    : 1.0
// ============================================================================
module tb_anticipator_table;

  localparam int ADDR_W   = 4;
  localparam int NPORTS   = 4;
  localparam int CNT_W    = 2;
  localparam int INIT_VAL = 1;
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  anticipator_table_if #(.ADDR_W(ADDR_W), .NPORTS(NPORTS), .CNT_W(CNT_W)) bus ();

  anticipator_table #(
    .ADDR_W  (ADDR_W),
    .NPORTS  (NPORTS),
    .CNT_W   (CNT_W),
    .INIT_VAL(INIT_VAL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model: table contents, cycles of init left, expected read outputs.
  int m_tab [DEPTH];
  int m_left;
  int exp_data [NPORTS];
  bit exp_valid [NPORTS];

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic int port_data(int p);
    return int'(bus.read_data[p*CNT_W +: CNT_W]);
  endfunction

  task automatic set_read(int p, int a, bit en);
    bus.read_en[p]                     = en;
    bus.read_addr[p*ADDR_W +: ADDR_W]  = ADDR_W'(a);
  endtask

  task automatic drive_idle();
    bus.flush     = 1'b0;
    bus.read_en   = '0;
    bus.read_addr = '0;
    bus.upd_en    = 1'b0;
    bus.upd_addr  = '0;
    bus.upd_taken = 1'b0;
  endtask

  task automatic m_reset();
    m_left = DEPTH;
    for (int p = 0; p < NPORTS; p++) begin
      exp_data[p]  = 0;
      exp_valid[p] = 1'b0;
    end
  endtask

  // Applies one clock edge of the table's rules to the model, using the inputs now on the bus.
  task automatic model_edge();
    for (int p = 0; p < NPORTS; p++) begin
      if (m_left > 0) begin
        exp_valid[p] = 1'b0;
        exp_data[p]  = 0;
      end else if (bus.read_en[p]) begin
        exp_valid[p] = 1'b1;
        exp_data[p]  = m_tab[int'(bus.read_addr[p*ADDR_W +: ADDR_W])];
      end else begin
        exp_valid[p] = 1'b0;
      end
    end
    if (m_left > 0) begin
      m_tab[DEPTH - m_left] = INIT_VAL;
      m_left = bus.flush ? DEPTH : m_left - 1;
    end else if (bus.flush) begin
      m_left = DEPTH;
    end else if (bus.upd_en) begin
      int a = int'(bus.upd_addr);
      if (bus.upd_taken) m_tab[a] = (m_tab[a] < CMAX) ? m_tab[a] + 1 : CMAX;
      else               m_tab[a] = (m_tab[a] > 0)    ? m_tab[a] - 1 : 0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    #2 rst = 1'b1;
    #1;
    m_reset();
    n_cmp++;
    if (bus.init_busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy: got %b want 1", bus.init_busy);
    end
    n_cmp++;
    if (bus.read_valid !== '0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", bus.read_valid);
    end
    n_cmp++;
    if (bus.read_data !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", bus.read_data);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_init_sweep();
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (bus.init_busy !== 1'b1) begin
        n_fail++; $display("FAIL sweep_busy: cycle %0d got %b want 1", i, bus.init_busy);
      end
      n_cmp++;
      if (bus.read_valid !== '0) begin
        n_fail++; $display("FAIL sweep_valid: cycle %0d got %b want 0", i, bus.read_valid);
      end
      bus.read_en   = NPORTS'($urandom);
      bus.read_addr = (NPORTS*ADDR_W)'($urandom);
      bus.upd_en    = 1'b1;
      bus.upd_addr  = ADDR_W'($urandom);
      bus.upd_taken = 1'($urandom);
      tick();
    end
    drive_idle();
    n_cmp++;
    if (bus.init_busy !== 1'b0) begin
      n_fail++; $display("FAIL sweep_done: got %b want 0", bus.init_busy);
    end
    for (int c = 0; c < DEPTH / NPORTS; c++) begin
      for (int p = 0; p < NPORTS; p++) set_read(p, c*NPORTS + p, 1'b1);
      tick();
      for (int p = 0; p < NPORTS; p++) begin
        n_cmp++;
        if (bus.read_valid[p] !== 1'b1 || port_data(p) != INIT_VAL) begin
          n_fail++;
          $display("FAIL init_value: entry %0d got valid %b data %0d want valid 1 data %0d",
                   c*NPORTS + p, bus.read_valid[p], port_data(p), INIT_VAL);
        end
      end
    end
    drive_idle();
  endtask

  task automatic test_saturate();
    bit seq_taken [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int seq_exp   [7] = '{2, 3, 3, 2, 1, 0, 0};
    for (int i = 0; i < 7; i++) begin
      drive_idle();
      bus.upd_en    = 1'b1;
      bus.upd_addr  = ADDR_W'(5);
      bus.upd_taken = seq_taken[i];
      tick();
      drive_idle();
      set_read(0, 5, 1'b1);
      tick();
      n_cmp++;
      if (bus.read_valid[0] !== 1'b1 || port_data(0) != seq_exp[i]) begin
        n_fail++;
        $display("FAIL saturate: step %0d got valid %b data %0d want valid 1 data %0d",
                 i, bus.read_valid[0], port_data(0), seq_exp[i]);
      end
    end
    drive_idle();
  endtask

  task automatic test_same_cycle();
    drive_idle();
    bus.upd_en = 1'b1; bus.upd_addr = ADDR_W'(7); bus.upd_taken = 1'b1;
    tick();
    set_read(0, 7, 1'b1);
    tick();
    n_cmp++;
    if (port_data(0) != 2 || bus.read_valid[0] !== 1'b1) begin
      n_fail++; $display("FAIL same_cycle_pre: got %0d valid %b want 2 valid 1", port_data(0), bus.read_valid[0]);
    end
    drive_idle();
    set_read(0, 7, 1'b1);
    tick();
    n_cmp++;
    if (port_data(0) != 3) begin
      n_fail++; $display("FAIL same_cycle_post: got %0d want 3", port_data(0));
    end
    drive_idle();
    tick();
    n_cmp++;
    if (bus.read_valid[0] !== 1'b0 || port_data(0) != 3) begin
      n_fail++; $display("FAIL hold: got valid %b data %0d want valid 0 data 3", bus.read_valid[0], port_data(0));
    end
  endtask

  task automatic test_multi_port();
    drive_idle();
    for (int p = 0; p < NPORTS; p++) set_read(p, 9, 1'b1);
    tick();
    n_cmp++;
    if (bus.read_valid !== 4'b1111) begin
      n_fail++; $display("FAIL multi_valid: got %b want 1111", bus.read_valid);
    end
    for (int p = 0; p < NPORTS; p++) begin
      n_cmp++;
      if (port_data(p) != INIT_VAL) begin
        n_fail++; $display("FAIL multi_data: port %0d got %0d want %0d", p, port_data(p), INIT_VAL);
      end
    end
    drive_idle();
  endtask

  task automatic test_flush_read();
    int cnt;
    drive_idle();
    set_read(2, 7, 1'b1);
    bus.flush = 1'b1;
    tick();
    drive_idle();
    n_cmp++;
    if (bus.read_valid[2] !== 1'b1 || port_data(2) != 3 || bus.init_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_read: got valid %b data %0d busy %b want valid 1 data 3 busy 1",
               bus.read_valid[2], port_data(2), bus.init_busy);
    end
    set_read(2, 7, 1'b1);
    tick();
    n_cmp++;
    if (bus.read_valid !== '0 || bus.read_data !== '0) begin
      n_fail++; $display("FAIL init_reads: got valid %b data %h want 0 0", bus.read_valid, bus.read_data);
    end
    drive_idle();
    cnt = 0;
    while (bus.init_busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    n_cmp++;
    if (bus.init_busy !== 1'b0) begin
      n_fail++; $display("FAIL flush_sweep_end: busy %b after %0d cycles want 0", bus.init_busy, cnt);
    end
  endtask

  task automatic test_flush_init();
    int cnt;
    drive_idle();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    repeat (6) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    cnt = 0;
    while (bus.init_busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    n_cmp++;
    if (cnt != DEPTH) begin
      n_fail++; $display("FAIL flush_restart: busy for %0d cycles want %0d", cnt, DEPTH);
    end
  endtask

  task automatic test_upd_ignored();
    int cnt;
    drive_idle();
    for (int a = 0; a < 4; a++) begin
      bus.upd_en = 1'b1; bus.upd_addr = ADDR_W'(a); bus.upd_taken = 1'b1;
      tick();
    end
    bus.upd_addr = ADDR_W'(4);
    bus.flush    = 1'b1;
    tick();
    bus.flush = 1'b0;
    cnt = 0;
    while (bus.init_busy === 1'b1 && cnt < 40) begin
      bus.upd_en    = 1'b1;
      bus.upd_addr  = ADDR_W'($urandom);
      bus.upd_taken = 1'($urandom);
      cnt++;
      tick();
    end
    drive_idle();
    for (int c = 0; c < DEPTH / NPORTS; c++) begin
      for (int p = 0; p < NPORTS; p++) set_read(p, c*NPORTS + p, 1'b1);
      tick();
      for (int p = 0; p < NPORTS; p++) begin
        n_cmp++;
        if (bus.read_valid[p] !== 1'b1 || port_data(p) != INIT_VAL) begin
          n_fail++;
          $display("FAIL upd_ignored: entry %0d got valid %b data %0d want valid 1 data %0d",
                   c*NPORTS + p, bus.read_valid[p], port_data(p), INIT_VAL);
        end
      end
    end
    drive_idle();
  endtask

  task automatic test_rst_mid();
    int cnt;
    for (int s = 0; s < 2; s++) begin
      drive_idle();
      if (s == 0) begin
        set_read(1, 3, 1'b1);
        tick();
      end else begin
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        repeat (5) tick();
      end
      rst = 1'b1;
      #1;
      m_reset();
      n_cmp++;
      if (bus.init_busy !== 1'b1 || bus.read_valid !== '0 || bus.read_data !== '0) begin
        n_fail++;
        $display("FAIL rst_mid: case %0d got busy %b valid %b data %h want 1 0 0",
                 s, bus.init_busy, bus.read_valid, bus.read_data);
      end
      drive_idle();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      cnt = 0;
      while (bus.init_busy === 1'b1 && cnt < 40) begin
        cnt++;
        tick();
      end
      n_cmp++;
      if (cnt != DEPTH) begin
        n_fail++; $display("FAIL rst_restart: case %0d busy for %0d cycles want %0d", s, cnt, DEPTH);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.read_en = NPORTS'($urandom);
      for (int p = 0; p < NPORTS; p++)
        bus.read_addr[p*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 7));
      bus.upd_en    = 1'($urandom);
      bus.upd_addr  = ADDR_W'($urandom_range(0, 3));
      bus.upd_taken = 1'($urandom);
      bus.flush     = ($urandom_range(0, 59) == 0);
      tick();
      n_cmp++;
      if (bus.init_busy !== (m_left > 0)) begin
        n_fail++; $display("FAIL rand_busy: cycle %0d got %b want %b", i, bus.init_busy, (m_left > 0));
      end
      for (int p = 0; p < NPORTS; p++) begin
        n_cmp++;
        if (bus.read_valid[p] !== exp_valid[p] || port_data(p) != exp_data[p]) begin
          n_fail++;
          $display("FAIL rand_read: cycle %0d port %0d got valid %b data %0d want valid %b data %0d",
                   i, p, bus.read_valid[p], port_data(p), exp_valid[p], exp_data[p]);
        end
      end
    end
    drive_idle();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_tab[i] = 0;
    test_reset();
    test_init_sweep();
    test_saturate();
    test_same_cycle();
    test_multi_port();
    test_flush_read();
    test_flush_init();
    test_upd_ignored();
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
